// File: rtl/max_onehot_finder.sv
// max_onehot_finder: captures four candidates on start, scans them one per cycle and
// reports the maximum as a registered one-hot select (sel[3]=i_0 .. sel[0]=i_3) plus its value.
module max_onehot_finder #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i_0,
    input  logic [WIDTH-1:0] i_1,
    input  logic [WIDTH-1:0] i_2,
    input  logic [WIDTH-1:0] i_3,
    output logic [3:0]       sel,
    output logic [WIDTH-1:0] max_val,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_cap [4];
    logic [WIDTH-1:0] r_best_val;
    logic [3:0]       r_best_oh;

    logic [WIDTH-1:0] w_cand;
    logic [WIDTH-1:0] w_next_val;
    logic [3:0]       w_next_oh;
    logic             w_take;

    function automatic logic [3:0] cnt_to_oh(input logic [1:0] cnt);
        logic [3:0] oh;
        case (cnt)
            2'd0:    oh = 4'b1000;
            2'd1:    oh = 4'b0100;
            2'd2:    oh = 4'b0010;
            2'd3:    oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Running maximum after folding in the candidate selected by r_cnt; strict > keeps the first of equal maxima
    always_comb begin
        w_cand = r_cap[r_cnt];
        if (r_cnt == 2'd0) begin
            w_take = 1'b1;
        end else if (w_cand > r_best_val) begin
            w_take = 1'b1;
        end else begin
            w_take = 1'b0;
        end
        if (w_take) begin
            w_next_val = w_cand;
            w_next_oh  = cnt_to_oh(r_cnt);
        end else begin
            w_next_val = r_best_val;
            w_next_oh  = r_best_oh;
        end
    end

    // Control FSM with registered result and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_best_val <= '0;
            r_best_oh  <= 4'b0000;
            sel        <= 4'b0000;
            max_val    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_cap[0] <= i_0;
                        r_cap[1] <= i_1;
                        r_cap[2] <= i_2;
                        r_cap[3] <= i_3;
                        sel      <= 4'b0000;
                        max_val  <= '0;
                        r_cnt    <= 2'd0;
                        busy     <= 1'b1;
                        r_state  <= ST_CMP;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    r_best_val <= w_next_val;
                    r_best_oh  <= w_next_oh;
                    r_cnt      <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        sel     <= w_next_oh;
                        max_val <= w_next_val;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_CMP;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_onehot_finder.sv
// Scoreboard bench for max_onehot_finder: driver pushes hand-computed results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_max_onehot_finder;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] i_0, i_1, i_2, i_3;
    logic [3:0]       sel;
    logic [WIDTH-1:0] max_val;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] v0, v1, v2, v3;
        logic [3:0]       exp_sel;
        logic [WIDTH-1:0] exp_max;
    } vec_t;

    vec_t q[$];
    vec_t tbl[14];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit b2b_mode = 1'b0;

    max_onehot_finder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
        .sel(sel), .max_val(max_val), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Downstream one-hot mux model driven by sel
    function automatic logic [WIDTH-1:0] mux4(input logic [3:0] s, input vec_t v);
        logic [WIDTH-1:0] r;
        r = '0;
        if (s[3]) r = r | v.v0;
        if (s[2]) r = r | v.v1;
        if (s[1]) r = r | v.v2;
        if (s[0]) r = r | v.v3;
        return r;
    endfunction

    // Monitor: pops the scoreboard on done and checks sel/max_val/mux/busy/done timing
    logic [4:0] busy_hist = 5'b00000;
    bit         prev_done = 1'b0;
    bit         have_last = 1'b0;
    int         last_done = 0;
    always @(negedge clk) begin
        cyc++;
        if (mon_en && !rst) begin
            check("sel_onehot_or_zero", int'((sel == 4'b0000) || $onehot(sel)), 1);
            if (prev_done) check("done_single_cycle", int'(done), 0);
            if (!b2b_mode) have_last = 1'b0;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    check("sel", int'(sel), int'(e.exp_sel));
                    check("max_val", int'(max_val), int'(e.exp_max));
                    check("mux_eq_max", int'(mux4(sel, e)), int'(e.exp_max));
                    check("busy_at_done", int'(busy), 0);
                    check("busy_4_cycles", int'(busy_hist), 5'b01111);
                end
                if (b2b_mode && have_last) check("done_period", cyc - last_done, 6);
                have_last = 1'b1;
                last_done = cyc;
            end
        end
        busy_hist = {busy_hist[3:0], busy};
        prev_done = done;
    end

    task automatic set_in(input vec_t v);
        i_0 = v.v0; i_1 = v.v1; i_2 = v.v2; i_3 = v.v3;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_drain_timeout"}, q.size(), 0);
    endtask

    task automatic run_search(input vec_t v);
        set_in(v);
        start = 1'b1;
        @(posedge clk); #1;
        q.push_back(v);
        start = 1'b0;
        wait_drain("search");
    endtask

    initial begin
        tbl[0]  = '{5'd3,  5'd17, 5'd9,  5'd30, 4'b0001, 5'd30};
        tbl[1]  = '{5'd12, 5'd31, 5'd31, 5'd5,  4'b0100, 5'd31};
        tbl[2]  = '{5'd0,  5'd0,  5'd0,  5'd0,  4'b1000, 5'd0};
        tbl[3]  = '{5'd20, 5'd7,  5'd25, 5'd1,  4'b0010, 5'd25};
        tbl[4]  = '{5'd31, 5'd0,  5'd0,  5'd31, 4'b1000, 5'd31};
        tbl[5]  = '{5'd1,  5'd2,  5'd3,  5'd4,  4'b0001, 5'd4};
        tbl[6]  = '{5'd5,  5'd5,  5'd5,  5'd5,  4'b1000, 5'd5};
        tbl[7]  = '{5'd9,  5'd30, 5'd2,  5'd30, 4'b0100, 5'd30};
        tbl[8]  = '{5'd8,  5'd1,  5'd2,  5'd3,  4'b1000, 5'd8};
        tbl[9]  = '{5'd1,  5'd8,  5'd2,  5'd3,  4'b0100, 5'd8};
        tbl[10] = '{5'd1,  5'd2,  5'd8,  5'd3,  4'b0010, 5'd8};
        tbl[11] = '{5'd1,  5'd2,  5'd3,  5'd8,  4'b0001, 5'd8};
        tbl[12] = '{5'd0,  5'd0,  5'd31, 5'd30, 4'b0010, 5'd31};
        tbl[13] = '{5'd16, 5'd15, 5'd16, 5'd0,  4'b1000, 5'd16};

        rst = 1'b1; start = 1'b1;
        i_0 = 5'd7; i_1 = 5'd7; i_2 = 5'd7; i_3 = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_sel", int'(sel), 0);
        check("rst_max_val", int'(max_val), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        start = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_scan_without_start", int'(busy), 0);

        for (int i = 0; i < 3; i++) run_search(tbl[i]);

        // Captured inputs must win over later changes; start during CMP is dropped
        set_in(tbl[3]);
        start = 1'b1;
        @(posedge clk); #1;
        q.push_back(tbl[3]);
        start = 1'b0;
        i_0 = 5'd31; i_1 = 5'd31; i_2 = 5'd31; i_3 = 5'd31;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain("stability");
        repeat (8) @(posedge clk);
        #1;
        check("hold_busy", int'(busy), 0);
        check("hold_sel", int'(sel), int'(tbl[3].exp_sel));
        check("hold_max_val", int'(max_val), int'(tbl[3].exp_max));

        for (int i = 4; i < 8; i++) run_search(tbl[i]);

        // Reset two edges into a scan must abort it without a done pulse
        set_in(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_sel", int'(sel), 0);
        check("midrst_max_val", int'(max_val), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        repeat (8) @(posedge clk);
        #1;
        check("midrst_stays_idle", int'(busy), 0);

        b2b_mode = 1'b1;
        start = 1'b1;
        for (int i = 8; i < 14; i++) begin
            set_in(tbl[i]);
            @(posedge clk); #1;
            q.push_back(tbl[i]);
            repeat (5) @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_drain("b2b");
        repeat (4) @(posedge clk);
        #1;
        b2b_mode = 1'b0;
        check("final_sel_held", int'(sel), int'(tbl[13].exp_sel));
        check("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
